// File: rtl/sequenciador_leds.sv
// rtl/sequenciador_leds.sv - playback controller that shows the stored color sequence on the LEDs
// Walks memory 0..latched limit, lighting each item for T_ON cycles, then blanking it for T_OFF cycles.
module sequenciador_leds #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int T_ON   = 1000,
   parameter int T_OFF  = 250
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] limite,
   input  logic [DATA_W-1:0] mem_dado,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [2:0]        db_estado
);

   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TMR_W-1:0] ON_ULTIMO  = TMR_W'(T_ON - 1);
   localparam logic [TMR_W-1:0] OFF_ULTIMO = TMR_W'(T_OFF - 1);

   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] CARREGA = 3'd1;
   localparam logic [2:0] ACESO   = 3'd2;
   localparam logic [2:0] APAGADO = 3'd3;
   localparam logic [2:0] PROXIMO = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

   logic [2:0]        estado_q,   estado_d;
   logic [ADDR_W-1:0] endereco_q, endereco_d;
   logic [ADDR_W-1:0] limite_q,   limite_d;
   logic [DATA_W-1:0] leds_q,     leds_d;
   logic [TMR_W-1:0]  timer_q,    timer_d;
   logic              ocupado_q,  ocupado_d;
   logic              pronto_q,   pronto_d;

   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      leds_d     = leds_q;
      timer_d    = timer_q;

      case (estado_q)
         OCIOSO: begin
            if (iniciar) begin
               estado_d   = CARREGA;
               endereco_d = '0;
               limite_d   = limite;
               timer_d    = '0;
            end
         end
         CARREGA: begin
            leds_d   = mem_dado;
            estado_d = ACESO;
         end
         ACESO: begin
            if (timer_q == ON_ULTIMO) begin
               timer_d  = '0;
               leds_d   = '0;
               estado_d = APAGADO;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         APAGADO: begin
            if (timer_q == OFF_ULTIMO) begin
               timer_d  = '0;
               estado_d = PROXIMO;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         PROXIMO: begin
            // Stopping on equality keeps the address from ever wrapping.
            if (endereco_q == limite_q) begin
               estado_d = FIM;
            end else begin
               endereco_d = endereco_q + 1'b1;
               estado_d   = CARREGA;
            end
         end
         FIM: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
            leds_d   = '0;
            timer_d  = '0;
         end
      endcase

      // Abort overrides every busy transition; the address is left where it was.
      if (abortar && (estado_q != OCIOSO)) begin
         estado_d   = OCIOSO;
         leds_d     = '0;
         timer_d    = '0;
         endereco_d = endereco_q;
      end

      ocupado_d = (estado_d != OCIOSO);
      pronto_d  = (estado_d == FIM);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         endereco_q <= '0;
         limite_q   <= '0;
         leds_q     <= '0;
         timer_q    <= '0;
         ocupado_q  <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         leds_q     <= leds_d;
         timer_q    <= timer_d;
         ocupado_q  <= ocupado_d;
         pronto_q   <= pronto_d;
      end
   end

   assign mem_endereco = endereco_q;
   assign leds         = leds_q;
   assign ocupado      = ocupado_q;
   assign pronto       = pronto_q;
   assign db_estado    = estado_q;

endmodule

// File: tb/tb_sequenciador_leds.sv
// tb/tb_sequenciador_leds.sv - scoreboard bench for sequenciador_leds
// Expected LED on/off and pronto events are computed per run and popped by a monitor.
module tb_sequenciador_leds;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int T_ON   = 4;
   localparam int T_OFF  = 2;
   localparam int P      = T_ON + T_OFF + 2;
   localparam int MAXC   = 8192;

   localparam int EV_ON     = 0;
   localparam int EV_OFF    = 1;
   localparam int EV_PRONTO = 2;

   typedef struct {
      int         kind;
      logic [3:0] val;
      int         cyc;
   } ev_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              iniciar = 1'b0;
   logic              abortar = 1'b0;
   logic [ADDR_W-1:0] limite = '0;
   logic [DATA_W-1:0] mem_dado;
   logic [ADDR_W-1:0] mem_endereco;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              pronto;
   logic [2:0]        db_estado;

   logic [DATA_W-1:0] mem [0:15];
   bit                exp_busy [0:MAXC-1];
   ev_t               exp_q [$];
   logic [DATA_W-1:0] prev_leds = '0;
   int                cyc = 0;
   int                n_checks = 0;
   int                n_fail = 0;

   sequenciador_leds #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ON(T_ON), .T_OFF(T_OFF)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .abortar      (abortar),
      .limite       (limite),
      .mem_dado     (mem_dado),
      .mem_endereco (mem_endereco),
      .leds         (leds),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   assign mem_dado = mem[mem_endereco];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input logic [3:0] val, input int c);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic sb_event(input int kind, input logic [3:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d value %b at cycle %0d, required none", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.cyc);
         if (kind == EV_ON) chk("led_value", val, e.val);
      end
   endtask

   // Reference: start accepted into CARREGA period s; item i lit from s+1+i*P for T_ON periods.
   task automatic plan_run(input int s, input int L, input int ab, output int last, output int addr);
      int n;
      int done;
      int on;
      int off;
      n    = L + 1;
      done = s + n * P;
      last = (ab >= 0 && ab < done) ? ab : done;
      for (int c = s; c <= last; c++) if (c < MAXC) exp_busy[c] = 1'b1;
      for (int i = 0; i < n; i++) begin
         on  = s + 1 + i * P;
         off = on + T_ON;
         if (on > last) break;
         push_ev(EV_ON, mem[i], on);
         if (off > last) begin
            push_ev(EV_OFF, 4'd0, last + 1);
            break;
         end
         push_ev(EV_OFF, 4'd0, off);
      end
      if (done <= last) push_ev(EV_PRONTO, 4'd0, done);
      addr = (ab >= 0 && ab < done) ? (ab - s) / P : L;
   endtask

   always @(negedge clock) begin
      if (cyc < MAXC) chk("ocupado", ocupado, exp_busy[cyc]);
      if (pronto) chk("pronto_leds_dark", leds, 0);
      if (leds !== prev_leds) begin
         if (leds != 0) sb_event(EV_ON, leds);
         else sb_event(EV_OFF, 4'd0);
      end
      if (pronto) sb_event(EV_PRONTO, 4'd0);
      prev_leds = leds;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         abortar = 1'($urandom_range(0, 1));
      end
      abortar = 1'b0;
   endtask

   // mode: 0 plain, 1 abortar together with the start, 2 poke limite/iniciar in first ACESO, 3 random noise
   task automatic run_seq(input int L, input int ab_off, input int mode);
      int s, ab, last, addr;
      @(negedge clock);
      limite  = 4'(L);
      iniciar = 1'b1;
      abortar = (mode == 1);
      s  = cyc + 1;
      ab = (ab_off >= 0) ? s + ab_off : -1;
      plan_run(s, L, ab, last, addr);
      @(negedge clock);
      while (cyc <= last) begin
         abortar = (cyc == ab);
         iniciar = 1'b0;
         if (mode == 2 && cyc == s + 2) begin
            iniciar = 1'b1;
            limite  = 4'd3;
         end
         if (mode == 3) begin
            iniciar = ($urandom_range(0, 3) == 0);
            limite  = 4'($urandom);
         end
         @(negedge clock);
      end
      iniciar = 1'b0;
      abortar = 1'b0;
      chk("end_address", mem_endereco, addr);
      chk("end_state", db_estado, 0);
   endtask

   task automatic run_held(input int L);
      int s1, s2, last1, last2, addr;
      @(negedge clock);
      limite  = 4'(L);
      iniciar = 1'b1;
      s1 = cyc + 1;
      plan_run(s1, L, -1, last1, addr);
      s2 = last1 + 2;
      plan_run(s2, L, -1, last2, addr);
      while (cyc < s2) @(negedge clock);
      iniciar = 1'b0;
      while (cyc <= last2) @(negedge clock);
      chk("held_end_address", mem_endereco, addr);
      chk("held_end_state", db_estado, 0);
   endtask

   task automatic reset_mid_aceso();
      int s, c, last, addr;
      @(negedge clock);
      limite  = 4'd3;
      iniciar = 1'b1;
      s = cyc + 1;
      plan_run(s, 3, -1, last, addr);
      @(negedge clock);
      iniciar = 1'b0;
      while (cyc < s + 3) @(negedge clock);
      #2 reset = 1'b0;
      c = cyc;
      #1;
      chk("async_reset_leds", leds, 0);
      chk("async_reset_estado", db_estado, 0);
      chk("async_reset_ocupado", ocupado, 0);
      chk("async_reset_endereco", mem_endereco, 0);
      exp_q.delete();
      push_ev(EV_OFF, 4'd0, c + 1);
      for (int k = c + 1; k <= last; k++) if (k < MAXC) exp_busy[k] = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      idle(6);
      chk("idle_after_reset", db_estado, 0);
   endtask

   initial begin
      mem[0] = 4'b0001;
      mem[1] = 4'b0100;
      mem[2] = 4'b1000;
      mem[3] = 4'b0010;
      for (int i = 4; i < 16; i++) mem[i] = 4'(1 << (i % 4));

      repeat (3) @(negedge clock);
      chk("reset_leds", leds, 0);
      chk("reset_endereco", mem_endereco, 0);
      chk("reset_ocupado", ocupado, 0);
      chk("reset_pronto", pronto, 0);
      chk("reset_estado", db_estado, 0);
      reset = 1'b1;
      idle(3);

      run_seq(0, -1, 0);
      idle(3);
      run_seq(3, -1, 0);
      idle(2);
      run_seq(1, -1, 2);
      idle(2);
      run_seq(3, P + 2, 0);
      run_seq(2, -1, 0);
      idle(2);
      run_seq(1, -1, 1);
      run_held(1);
      idle(2);
      reset_mid_aceso();
      run_seq(15, -1, 0);
      idle(2);

      for (int r = 0; r < 10; r++) begin
         int L, ab_off, mode;
         for (int i = 4; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
         L      = $urandom_range(0, 15);
         ab_off = ($urandom_range(0, 1) == 1) ? $urandom_range(0, (L + 1) * P) : -1;
         mode   = ($urandom_range(0, 1) == 1) ? 3 : 0;
         run_seq(L, ab_off, mode);
         idle($urandom_range(1, 4));
      end

      idle(5);
      chk("leftover_expected_events", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sequenciador_leds.md
# sequenciador_leds

Playback controller that shows the stored color sequence to the player before each round of the memory game. On a start pulse it walks the sequence memory from address 0 up to a latched limit. It lights each stored value on the LEDs for a fixed on-time, then blanks them for a fixed gap, and finally pulses `pronto`. It sits beside the game control unit and the memory-address counter, and owns the memory address bus while `ocupado` is high.

## Interface

- `ADDR_W`, default 4: sequence memory address width.
- `DATA_W`, default 4: LED/memory word width (one-hot color).
- `T_ON`, default 1000: cycles each value is lit; must be ≥1.
- `T_OFF`, default 250: cycles of blanking after each value; must be ≥1.

Ports:

- `clock` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low; forces the reset state immediately.
- `iniciar` input 1: start request, sampled only in OCIOSO.
- `abortar` input 1: cancels playback from any busy state.
- `limite` input ADDR_W: last address to play; latched when the start is accepted.
- `mem_dado` input DATA_W: memory read data, combinational from `mem_endereco`.
- `mem_endereco` output ADDR_W: registered address of the current item.
- `leds` output DATA_W: registered LED drive.
- `ocupado` output 1: high in every state except OCIOSO.
- `pronto` output 1: one-cycle pulse when the sequence completes normally.
- `db_estado` output 3: current state code, for debug.

## Operation

State codes: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, PROXIMO=4, FIM=5.

- Reset values: state OCIOSO; `mem_endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0; internal timer=0; latched limit=0.
- OCIOSO:
  - `iniciar`=1 → CARREGA; `mem_endereco`←0, limit←`limite`, timer←0.
  - `abortar` is ignored here, including when it arrives together with `iniciar`.
- CARREGA (1 cycle): internal LED register←`mem_dado` → ACESO.
- ACESO:
  - `leds` = latched value; timer counts up.
  - When timer reaches T_ON-1: timer←0 → APAGADO.
- APAGADO:
  - `leds`=0; timer counts up.
  - When timer reaches T_OFF-1: timer←0 → PROXIMO.
- PROXIMO (1 cycle):
  - If `mem_endereco`==latched limit → FIM.
  - Otherwise `mem_endereco`←`mem_endereco`+1 → CARREGA.
- FIM (1 cycle): `pronto`=1 → OCIOSO. `iniciar` is ignored in this state.
- `abortar`=1 in CARREGA, ACESO, APAGADO, PROXIMO or FIM → OCIOSO next cycle.
  - `leds`←0, timer←0, no `pronto` pulse.
  - `mem_endereco` holds its value.
- `iniciar` outside OCIOSO is ignored. A change on `limite` during playback has no effect.
- Timer width is clog2(max(T_ON,T_OFF)) bits, unsigned, and never wraps.
- The address never increments past the latched limit, so there is no address wrap. `limite`=2^ADDR_W-1 plays every location.
- Reset asserted mid-playback: all outputs return to reset values asynchronously. After reset releases, the block waits in OCIOSO.

## Timing

- `iniciar` sampled high at edge k: CARREGA is active in cycle k+1.
- Each item costs T_ON+T_OFF+2 cycles: CARREGA, ACESO, APAGADO, PROXIMO.
- With N = latched limit + 1 items, `pronto` is high exactly in cycle k+1+N·(T_ON+T_OFF+2). `ocupado` drops the cycle after.
- `leds` shows the item from cycle CARREGA+1 for exactly T_ON cycles, then 0 for T_OFF cycles.
- `mem_endereco` is stable from PROXIMO+1 through the next PROXIMO. Memory data is therefore valid when CARREGA samples it.
- `pronto` is never asserted together with `leds`≠0.

## Test plan

Use T_ON=4, T_OFF=2, memory {0:0001, 1:0100, 2:1000, 3:0010}.

- Reset: drive `reset`=0 mid-ACESO → `leds`=0, `db_estado`=0, `ocupado`=0 without waiting for an edge. After release, the block stays in OCIOSO until `iniciar`.
- Single item: `limite`=0, `iniciar` at edge 0 → `leds`=0001 in cycles 2–5 and 0 in cycles 6–7. `pronto` is high in cycle 9 only; `ocupado` is high in cycles 1–9.
- Full sequence: `limite`=3 → LEDs show 0001, 0100, 1000, 0010 in order, each for 4 cycles separated by 2-cycle gaps. `pronto` fires in cycle 33, and `mem_endereco` ends at 3.
- Limit latching and ignored start: `limite`=1, then change `limite` to 3 and pulse `iniciar` during the first ACESO → only 2 items are played, and `pronto` fires in cycle 17.
- Abort: `limite`=3, `abortar` pulse in the second item's ACESO → the next cycle shows `leds`=0, `db_estado`=0, `ocupado`=0, with no `pronto` at any later time. A new `iniciar` restarts playback from address 0.
- Simultaneous events: `iniciar`=1 and `abortar`=1 together in OCIOSO → playback starts. `iniciar` held high through FIM → the block returns to OCIOSO for one cycle, then restarts.
